// File: rtl/ysyx_24100013_wbu.sv
// ysyx_24100013_wbu: writeback unit that performs load reads with byte/half/word extraction and drives a one-cycle register-file write.
module ysyx_24100013_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  input  logic                  ex_wen,
  input  logic                  ex_is_load,
  input  logic [2:0]            ex_funct3,
  input  logic [DATA_WIDTH-1:0] ex_result,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  wb_commit,
  output logic                  wb_misalign
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  wen_q, load_q;
  logic [2:0]            f3_q;
  logic [DATA_WIDTH-1:0] res_q, wdata_q, ld_data;
  logic                  hs, is_byte, is_half, mis, sx;
  logic [1:0]            a;
  logic [7:0]            b;
  logic [15:0]           h;
  // Held low through reset so nothing is accepted before the state register is valid.
  assign ex_ready      = rst_n & (state_q == IDLE);
  assign hs            = ex_valid & ex_ready;
  assign a             = res_q[1:0];
  assign is_byte       = f3_q[1:0] == 2'b00;
  assign is_half       = f3_q[1:0] == 2'b01;
  assign sx            = ~f3_q[2];
  assign mis           = is_half ? a[0] : (!is_byte && a != 2'b00);
  assign b             = mem_rsp_data[{a, 3'b000} +: 8];
  assign h             = a[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
  assign ld_data       = is_byte ? {{24{b[7] & sx}}, b} : is_half ? {{16{h[15] & sx}}, h} : mem_rsp_data;
  assign mem_req_valid = state_q == REQ;
  assign mem_req_addr  = {res_q[DATA_WIDTH-1:2], 2'b00};
  assign wb_commit     = state_q == WB;
  assign rf_wen        = wb_commit & wen_q & (rd_q != '0);
  assign wb_misalign   = wb_commit & load_q & mis;
  assign rf_rd         = rd_q;
  assign rf_wdata      = wdata_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = hs ? (ex_is_load ? REQ : WB) : IDLE;
      REQ:     state_d = mem_req_ready ? WAIT : REQ;
      WAIT:    state_d = mem_rsp_valid ? WB : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wen_q   <= 1'b0;
      load_q  <= 1'b0;
      f3_q    <= '0;
      res_q   <= '0;
      wdata_q <= '0;
    end else begin
      if (hs) begin
        rd_q    <= ex_rd;
        wen_q   <= ex_wen;
        load_q  <= ex_is_load;
        f3_q    <= ex_funct3;
        res_q   <= ex_result;
        wdata_q <= ex_result;
      end
      if (state_q == WAIT && mem_rsp_valid) wdata_q <= ld_data;
    end
  end
endmodule

// File: tb/tb_ysyx_24100013_wbu.sv
// tb_ysyx_24100013_wbu: vector table plus scoreboard of expected writebacks, checked whenever wb_commit pulses.
module tb_ysyx_24100013_wbu;
  logic        clk = 0, rst_n = 0;
  logic        ex_valid = 0, ex_ready, ex_wen = 0, ex_is_load = 0;
  logic [4:0]  ex_rd = 0, rf_rd;
  logic [2:0]  ex_funct3 = 0;
  logic [31:0] ex_result = 0, mem_req_addr, mem_rsp_data = 0, rf_wdata;
  logic        mem_req_valid, mem_req_ready = 0, mem_rsp_valid = 0;
  logic        rf_wen, wb_commit, wb_misalign;

  ysyx_24100013_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_funct3(ex_funct3),
    .ex_result(ex_result), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .wb_commit(wb_commit),
    .wb_misalign(wb_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] mem;
    int          dly;
    logic [31:0] exp;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
    logic        w;
    logic        m;
  } sb_t;

  vec_t v[12];
  sb_t  sb[$];
  int   n_chk = 0, n_fail = 0, commits = 0, cyc = 0;
  logic prev_wen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (rf_wen) chk("wen_single_pulse", {31'b0, prev_wen}, 32'd0);
    prev_wen = rf_wen;
    if (wb_commit) begin
      commits++;
      if (sb.size() == 0) chk("unexpected_commit", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("rf_wen", {31'b0, rf_wen}, {31'b0, e.w});
        if (e.w) chk("rf_rd", 32'(rf_rd), 32'(e.rd));
        chk("rf_wdata", rf_wdata, e.d);
        chk("wb_misalign", {31'b0, wb_misalign}, {31'b0, e.m});
      end
    end
  endtask

  task automatic check_reset_outs();
    chk("rst_ex_ready", {31'b0, ex_ready}, 32'd0);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
    chk("rst_commit", {31'b0, wb_commit}, 32'd0);
    chk("rst_misalign", {31'b0, wb_misalign}, 32'd0);
    chk("rst_rf_rd", 32'(rf_rd), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
  endtask

  task automatic drive(input vec_t x);
    ex_is_load = x.ld; ex_funct3 = x.f3; ex_result = x.res; ex_rd = x.rd; ex_wen = x.wen;
  endtask

  task automatic do_instr(input vec_t x);
    int t, c0;
    logic [31:0] a0;
    c0 = commits;
    sb.push_back('{x.rd, x.exp, x.wen && x.rd != 0, x.mis});
    drive(x);
    ex_valid = 1;
    t = 0;
    while (!ex_ready && t < 20) begin tick(); t++; end
    tick();
    ex_valid = 0;
    if (x.ld) begin
      t = 0;
      while (!mem_req_valid && t < 10) begin tick(); t++; end
      chk("req_valid", {31'b0, mem_req_valid}, 32'd1);
      a0 = {x.res[31:2], 2'b00};
      chk("req_addr", mem_req_addr, a0);
      for (int i = 0; i < x.dly; i++) begin
        tick();
        chk("req_hold_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("req_hold_addr", mem_req_addr, a0);
      end
      mem_req_ready = 1; tick(); mem_req_ready = 0;
      mem_rsp_valid = 1; mem_rsp_data = x.mem; tick(); mem_rsp_valid = 0;
    end
    t = 0;
    while (commits == c0 && t < 10) begin tick(); t++; end
    chk("commit_seen", 32'(commits - c0), 32'd1);
    tick();
    chk("ready_after_wb", {31'b0, ex_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, t, i;
    int acc[3];
    logic hs;
    vec_t b2b[3];
    v[0]  = '{1'b0, 3'b001, 32'hDEADBEEF, 5'd5,  1'b1, 32'h0,        0, 32'hDEADBEEF, 1'b0};
    v[1]  = '{1'b0, 3'b000, 32'h00001234, 5'd0,  1'b1, 32'h0,        0, 32'h00001234, 1'b0};
    v[2]  = '{1'b1, 3'b000, 32'h80000003, 5'd6,  1'b1, 32'h80FF7F01, 3, 32'hFFFFFF80, 1'b0};
    v[3]  = '{1'b1, 3'b101, 32'h80000002, 5'd7,  1'b1, 32'h8001ABCD, 0, 32'h00008001, 1'b0};
    v[4]  = '{1'b1, 3'b001, 32'h80000001, 5'd8,  1'b1, 32'h8001ABCD, 1, 32'hFFFFABCD, 1'b1};
    v[5]  = '{1'b1, 3'b100, 32'h80000002, 5'd9,  1'b1, 32'h80FF7F01, 0, 32'h000000FF, 1'b0};
    v[6]  = '{1'b1, 3'b010, 32'h80000006, 5'd10, 1'b1, 32'h12345678, 2, 32'h12345678, 1'b1};
    v[7]  = '{1'b1, 3'b111, 32'h00000010, 5'd11, 1'b1, 32'hCAFEBABE, 0, 32'hCAFEBABE, 1'b0};
    v[8]  = '{1'b1, 3'b010, 32'h00000020, 5'd12, 1'b0, 32'h55AA55AA, 0, 32'h55AA55AA, 1'b0};
    v[9]  = '{1'b0, 3'b000, 32'h00000003, 5'd3,  1'b0, 32'h0,        0, 32'h00000003, 1'b0};
    v[10] = '{1'b1, 3'b001, 32'h00000002, 5'd13, 1'b1, 32'h7FFF8000, 0, 32'h00007FFF, 1'b0};
    v[11] = '{1'b1, 3'b000, 32'h00000001, 5'd14, 1'b1, 32'h00008000, 0, 32'h00000080 | 32'h0, 1'b0};
    v[11].mem = 32'h00008000;
    v[11].exp = 32'hFFFFFF80;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs();
    rst_n = 1;
    tick();
    chk("ready_after_reset", {31'b0, ex_ready}, 32'd1);

    foreach (v[k]) do_instr(v[k]);

    // Back-to-back ALU ops with ex_valid held high
    b2b[0] = '{1'b0, 3'b000, 32'h00000011, 5'd1, 1'b1, 32'h0, 0, 32'h00000011, 1'b0};
    b2b[1] = '{1'b0, 3'b000, 32'h00000022, 5'd2, 1'b1, 32'h0, 0, 32'h00000022, 1'b0};
    b2b[2] = '{1'b0, 3'b000, 32'h00000033, 5'd3, 1'b1, 32'h0, 0, 32'h00000033, 1'b0};
    c0 = commits;
    for (int k = 0; k < 3; k++) sb.push_back('{b2b[k].rd, b2b[k].exp, 1'b1, 1'b0});
    i = 0; t = 0;
    drive(b2b[0]);
    ex_valid = 1;
    while (i < 3 && t < 20) begin
      hs = ex_ready;
      tick();
      t++;
      if (hs) begin
        acc[i] = cyc;
        i++;
        if (i < 3) drive(b2b[i]);
        else ex_valid = 0;
      end
    end
    ex_valid = 0;
    repeat (2) tick();
    chk("b2b_accepts", 32'(i), 32'd3);
    chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'd2);
    chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'd2);
    chk("b2b_commits", 32'(commits - c0), 32'd3);

    // Reset while in WAIT, then a stale response after release
    c0 = commits;
    drive('{1'b1, 3'b010, 32'h00000100, 5'd9, 1'b1, 32'h0, 0, 32'h0, 1'b0});
    ex_valid = 1; tick(); ex_valid = 0;
    chk("rw_req_valid", {31'b0, mem_req_valid}, 32'd1);
    mem_req_ready = 1; tick(); mem_req_ready = 0;
    repeat (2) tick();
    rst_n = 0;
    #1;
    check_reset_outs();
    @(posedge clk);
    #1;
    check_reset_outs();
    rst_n = 1;
    mem_rsp_valid = 1; mem_rsp_data = 32'hBADBAD00; tick(); mem_rsp_valid = 0;
    repeat (4) tick();
    chk("rw_no_commit", 32'(commits - c0), 32'd0);
    chk("rw_sb_empty", 32'(sb.size()), 32'd0);
    do_instr(v[0]);
    do_instr(v[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
